mem_access_arbiter: RTL and testbench

MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

---
 rtl/mem_access_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_access_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// Two-requester memory access arbiter (fetch + load/store) to a single
// MFA/MOC handshaked RAM port, with data-side priority and wait timeout.
module mem_access_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        IfReq,
   input  logic [31:0] IfAddr,
   output logic [31:0] IfRdata,
   output logic        IfDone,
   output logic        IfErr,
   input  logic        DReq,
   input  logic        DWrite,
   input  logic [1:0]  DSize,
   input  logic [31:0] DAddr,
   input  logic [31:0] DWdata,
   output logic [31:0] DRdata,
   output logic        DDone,
   output logic        DErr,
   output logic        MFA,
   output logic        RW,
   output logic [31:0] Addr,
   output logic [1:0]  Size,
   output logic [31:0] DataOut,
   input  logic [31:0] DataIn,
   input  logic        MOC,
   output logic        Busy,
   output logic [1:0]  Grant
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      COMPLETE,
      ABORT
   } state_t;

   localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       gdata;
   logic       misalign;

   always_comb begin
      misalign = 1'b0;
      unique case (1'b1)
         (DSize == 2'b01): misalign = DAddr[0];
         (DSize == 2'b10): misalign = (DAddr[1:0] != 2'b00);
         (DSize == 2'b11): misalign = 1'b1;
         default:          misalign = 1'b0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         gdata   <= 1'b0;
         MFA     <= 1'b0;
         RW      <= 1'b1;
         Addr    <= '0;
         Size    <= '0;
         DataOut <= '0;
         Busy    <= 1'b0;
         Grant   <= 2'b00;
         IfRdata <= '0;
         DRdata  <= '0;
         IfDone  <= 1'b0;
         IfErr   <= 1'b0;
         DDone   <= 1'b0;
         DErr    <= 1'b0;
      end else begin
         IfDone <= 1'b0;
         IfErr  <= 1'b0;
         DDone  <= 1'b0;
         DErr   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (DReq) begin
                  gdata <= 1'b1;
                  Grant <= 2'b10;
                  Busy  <= 1'b1;
                  // misaligned data never reaches the RAM
                  if (misalign) begin
                     state <= ABORT;
                     DErr  <= 1'b1;
                  end else begin
                     state   <= ISSUE;
                     MFA     <= 1'b1;
                     RW      <= ~DWrite;
                     Addr    <= DAddr;
                     Size    <= DSize;
                     DataOut <= DWdata;
                  end
               end else if (IfReq) begin
                  gdata <= 1'b0;
                  Grant <= 2'b01;
                  Busy  <= 1'b1;
                  state <= ISSUE;
                  MFA   <= 1'b1;
                  RW    <= 1'b1;
                  Addr  <= IfAddr;
                  Size  <= 2'b10;
               end
            end
            ISSUE: begin
               state <= WAIT;
               cnt   <= '0;
            end
            WAIT: begin
               if (MOC) begin
                  state <= COMPLETE;
                  MFA   <= 1'b0;
                  if (gdata) begin
                     DDone <= 1'b1;
                     if (RW) DRdata <= DataIn;
                  end else begin
                     IfDone  <= 1'b1;
                     IfRdata <= DataIn;
                  end
               end else if (cnt == TLAST) begin
                  state <= ABORT;
                  MFA   <= 1'b0;
                  if (gdata) DErr <= 1'b1;
                  else       IfErr <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            COMPLETE, ABORT: begin
               state <= IDLE;
               Busy  <= 1'b0;
               Grant <= 2'b00;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: expected responses are queued
// at request time and retired when Done/Err appears.
module tb_mem_access_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        IfReq;
   logic [31:0] IfAddr;
   logic [31:0] IfRdata;
   logic        IfDone, IfErr;
   logic        DReq, DWrite;
   logic [1:0]  DSize;
   logic [31:0] DAddr, DWdata, DRdata;
   logic        DDone, DErr;
   logic        MFA, RW;
   logic [31:0] Addr;
   logic [1:0]  Size;
   logic [31:0] DataOut, DataIn;
   logic        MOC;
   logic        Busy;
   logic [1:0]  Grant;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        isdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          mfa;
      logic [31:0] addr;
      logic        rw;
      logic [1:0]  size;
      logic [31:0] dout;
   } exp_t;

   exp_t sb[$];
   logic [31:0] i_rd, d_rd;
   logic [138:0] rst_exp;

   mem_access_arbiter #(.TIMEOUT(15)) dut (
      .Clk(Clk), .Reset(Reset),
      .IfReq(IfReq), .IfAddr(IfAddr), .IfRdata(IfRdata),
      .IfDone(IfDone), .IfErr(IfErr),
      .DReq(DReq), .DWrite(DWrite), .DSize(DSize), .DAddr(DAddr),
      .DWdata(DWdata), .DRdata(DRdata), .DDone(DDone), .DErr(DErr),
      .MFA(MFA), .RW(RW), .Addr(Addr), .Size(Size), .DataOut(DataOut),
      .DataIn(DataIn), .MOC(MOC), .Busy(Busy), .Grant(Grant)
   );

   always #5 Clk = ~Clk;

   task automatic push_exp(input logic isdata, input logic err,
                           input logic [31:0] rdata, input int lat,
                           input int mfa, input logic [31:0] addr,
                           input logic rw, input logic [1:0] size,
                           input logic [31:0] dout);
      exp_t e;
      e.isdata = isdata; e.err = err; e.rdata = rdata;
      e.lat = lat; e.mfa = mfa; e.addr = addr;
      e.rw = rw; e.size = size; e.dout = dout;
      sb.push_back(e);
   endtask

   // Drives MOC after moc_wait WAIT cycles (-1 = never) and retires
   // the head of the scoreboard when a Done/Err shows up.
   task automatic run_access(input int moc_wait, input logic [31:0] din);
      exp_t e;
      int cyc, mfa_n;
      bit got, stable_ok;
      logic [31:0] rd;
      e = sb[0];
      cyc = 0; mfa_n = 0; got = 0; stable_ok = 1;
      while (!got && cyc < 100) begin
         @(negedge Clk);
         cyc++;
         MOC = 1'b0;
         if (MFA) begin
            mfa_n++;
            if (Addr !== e.addr || RW !== e.rw || Size !== e.size ||
                (!e.rw && DataOut !== e.dout) ||
                Grant !== (e.isdata ? 2'b10 : 2'b01))
               stable_ok = 0;
         end
         if (IfDone | IfErr | DDone | DErr) begin
            got = 1;
            vectors++;
            if ($countones({IfDone, IfErr, DDone, DErr}) != 1) begin
               miscompares++;
               $display("FAIL resp_onehot: got %b want one bit",
                        {IfDone, IfErr, DDone, DErr});
            end
            vectors++;
            if ({DDone | DErr, IfErr | DErr} !== {e.isdata, e.err}) begin
               miscompares++;
               $display("FAIL resp_kind: got data/err %b want %b",
                        {DDone | DErr, IfErr | DErr}, {e.isdata, e.err});
            end
            rd = e.isdata ? DRdata : IfRdata;
            vectors++;
            if (rd !== e.rdata) begin
               miscompares++;
               $display("FAIL rdata: got %h want %h", rd, e.rdata);
            end
            vectors++;
            if (cyc != e.lat) begin
               miscompares++;
               $display("FAIL latency: got %0d want %0d", cyc, e.lat);
            end
            vectors++;
            if (mfa_n != e.mfa) begin
               miscompares++;
               $display("FAIL mfa_cycles: got %0d want %0d", mfa_n, e.mfa);
            end
            vectors++;
            if (!stable_ok) begin
               miscompares++;
               $display("FAIL ram_outputs: got bad Addr/RW/Size/DataOut/Grant want addr %h rw %b size %b",
                        e.addr, e.rw, e.size);
            end
            if (e.isdata) DReq = 1'b0;
            else IfReq = 1'b0;
         end else if (moc_wait >= 0 && cyc == moc_wait + 2) begin
            MOC = 1'b1;
            DataIn = din;
         end
      end
      void'(sb.pop_front());
      if (!got) begin
         vectors++;
         miscompares++;
         $display("FAIL resp_timeout: got no Done/Err want one within 100 cycles");
         IfReq = 1'b0;
         DReq = 1'b0;
      end
      MOC = 1'b0;
      @(negedge Clk);
      vectors++;
      if ({IfDone, IfErr, DDone, DErr, Busy, Grant} !== 7'b0) begin
         miscompares++;
         $display("FAIL idle_after: got %b want 0",
                  {IfDone, IfErr, DDone, DErr, Busy, Grant});
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      IfReq = 0; IfAddr = 0; DReq = 0; DWrite = 0; DSize = 0;
      DAddr = 0; DWdata = 0; DataIn = 0; MOC = 0;
      repeat (2) @(negedge Clk);
      vectors++;
      if ({MFA, RW, Grant, Busy, IfDone, IfErr, DDone, DErr, Addr, Size,
           DataOut, IfRdata, DRdata} !== rst_exp) begin
         miscompares++;
         $display("FAIL reset_state: got MFA %b RW %b Grant %b Busy %b Addr %h",
                  MFA, RW, Grant, Busy, Addr);
      end
      Reset = 1'b0;
      i_rd = '0;
      d_rd = '0;
   endtask

   task automatic test_fetch();
      i_rd = 32'hE3A01005;
      push_exp(0, 0, i_rd, 3, 2, 32'h10, 1, 2'b10, 32'h0);
      IfReq = 1; IfAddr = 32'h10;
      run_access(0, 32'hE3A01005);
   endtask

   task automatic test_priority();
      DReq = 1; DWrite = 1; DSize = 2'b10;
      DAddr = 32'h20; DWdata = 32'hDEADBEEF;
      IfReq = 1; IfAddr = 32'h40;
      push_exp(1, 0, d_rd, 3, 2, 32'h20, 0, 2'b10, 32'hDEADBEEF);
      i_rd = 32'h12345678;
      push_exp(0, 0, i_rd, 4, 3, 32'h40, 1, 2'b10, 32'h0);
      run_access(0, 32'h55555555);
      run_access(1, 32'h12345678);
      DWrite = 0;
   endtask

   task automatic test_misalign();
      logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
      logic [31:0] ad [3] = '{32'h22, 32'h13, 32'h0};
      for (int i = 0; i < 3; i++) begin
         DReq = 1; DWrite = 0; DSize = sz[i]; DAddr = ad[i];
         push_exp(1, 1, d_rd, 1, 0, 32'h0, 1, 2'b00, 32'h0);
         run_access(-1, 32'h0);
      end
   endtask

   task automatic test_timeout();
      push_exp(0, 1, i_rd, 17, 16, 32'h200, 1, 2'b10, 32'h0);
      IfReq = 1; IfAddr = 32'h200;
      run_access(-1, 32'h0);
      d_rd = 32'hCAFEF00D;
      push_exp(1, 0, d_rd, 17, 16, 32'h100, 1, 2'b10, 32'h0);
      DReq = 1; DWrite = 0; DSize = 2'b10; DAddr = 32'h100;
      run_access(14, 32'hCAFEF00D);
   endtask

   task automatic test_reset_wait();
      IfReq = 1; IfAddr = 32'h80;
      repeat (3) @(negedge Clk);
      vectors++;
      if (MFA !== 1'b1) begin
         miscompares++;
         $display("FAIL wait_mfa: got %b want 1", MFA);
      end
      Reset = 1'b1;
      IfReq = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
      vectors++;
      if ({MFA, RW, Grant, Busy, IfDone, IfErr, DDone, DErr, Addr, Size,
           DataOut, IfRdata, DRdata} !== rst_exp) begin
         miscompares++;
         $display("FAIL reset_mid_wait: got MFA %b RW %b Grant %b Busy %b Addr %h",
                  MFA, RW, Grant, Busy, Addr);
      end
      @(negedge Clk);
      MOC = 1'b1;
      DataIn = 32'hFFFFFFFF;
      repeat (2) begin
         @(negedge Clk);
         vectors++;
         if ({IfDone, IfErr, DDone, DErr, MFA, Busy} !== 6'b0 ||
             IfRdata !== 32'h0) begin
            miscompares++;
            $display("FAIL moc_after_reset: got flags %b rdata %h want 0",
                     {IfDone, IfErr, DDone, DErr, MFA, Busy}, IfRdata);
         end
      end
      MOC = 1'b0;
      i_rd = 32'h0BADF00D;
      d_rd = 32'h0;
      push_exp(0, 0, i_rd, 3, 2, 32'h84, 1, 2'b10, 32'h0);
      IfReq = 1; IfAddr = 32'h84;
      run_access(0, 32'h0BADF00D);
   endtask

   task automatic test_byte_load();
      d_rd = 32'h000000AB;
      push_exp(1, 0, d_rd, 7, 6, 32'h13, 1, 2'b00, 32'h0);
      DReq = 1; DWrite = 0; DSize = 2'b00; DAddr = 32'h13;
      run_access(4, 32'h000000AB);
   endtask

   initial begin
      rst_exp = {1'b0, 1'b1, 137'd0};
      test_reset();
      test_fetch();
      test_priority();
      test_misalign();
      test_timeout();
      test_reset_wait();
      test_byte_load();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
